lif_scheduler: RTL and testbench
================================

LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 Parameter THRESH, default 8'sd50, signed firing threshold.
REQ-002 Parameter RESET_V, default -8'sd20, signed post-spike membrane value.
REQ-003 Parameter REFRAC, default 2, number of updates a neuron ignores input after firing (0..3).
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port req, input, 4, per-neuron update request; bit k requests an update of neuron k.
REQ-007 Port i_syn, input, 32, four signed 8-bit synaptic currents; neuron k in bits [8k+7:8k].
REQ-008 Port gnt, output, 4, one-hot acknowledge, high for exactly one cycle when a request is accepted.
REQ-009 Port spike_valid, output, 1, one-cycle pulse marking a completed update; high only if the neuron fired.
REQ-010 Port spike_id, output, 2, index of the most recently updated neuron.
REQ-011 Port v_mem, output, 8, signed new membrane value of the most recently updated neuron.
REQ-012 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL hold four signed 8-bit membrane registers V[0..3], four refractory counters and a 2-bit round-robin pointer ptr.
REQ-014 The FSM SHALL have states IDLE, CALC and WB; IDLE->CALC on grant, CALC->WB unconditionally, WB->IDLE unconditionally.
REQ-015 In IDLE with any req bit set, the block SHALL grant the first set bit at or after ptr (wrapping 3->0), pulse gnt, and latch the index and that neuron's i_syn in the same cycle.
REQ-016 No gnt SHALL be issued outside IDLE; requests SHALL be level-held by requesters until gnt; a request dropped before gnt is discarded without side effects.
REQ-017 Throughput SHALL be one update per 3 cycles; spike_valid/v_mem/spike_id SHALL update in the WB cycle, 2 cycles after gnt.
REQ-018 In CALC, if V >= THRESH the next value SHALL be RESET_V, spike flagged, and the refractory counter loaded with REFRAC.
REQ-019 Otherwise, if the refractory counter is nonzero, the next value SHALL be V unchanged (input ignored) and the counter decremented.
REQ-020 Otherwise next = V + (I >>> 2) + (V >>> 3)*(V >>> 3), using arithmetic (floor) shifts, 16-bit signed intermediates, saturated to [-128, 127].
REQ-021 In WB the block SHALL write next into V[index], drive v_mem=next and spike_id=index, and set ptr = index+1 mod 4.
REQ-022 A request from the neuron currently being processed SHALL be served after all other pending requests, per the pointer rule.
REQ-023 spike_valid SHALL be low in every cycle other than a WB cycle in which the neuron fired.

Reset
REQ-024 On rst_n low, immediately and independently of clk: FSM=IDLE, all V=0, all refractory counters=0, ptr=0, gnt=0, spike_valid=0, spike_id=0, v_mem=0, busy=0.
REQ-025 A reset during CALC or WB SHALL abort the update with no write to V; operation resumes from IDLE on the first edge after rst_n rises.

Verification
REQ-026 Neuron 0 alone, i_syn[7:0]=40 held, req[0]=1 -> successive v_mem 10, 21, 35, 61, then -20 with spike_valid=1, spike_id=0 on the 5th update.
REQ-027 After that spike, two further updates with i_syn=40 -> v_mem -20, -20 (refractory); third update -> -20+10+9 = -1.
REQ-028 req=4'b1111 held from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, with gnt pulses exactly 3 cycles apart.
REQ-029 Neuron 2 only, i_syn=-128 held -> v_mem -32, -48, -44, -40; spike_valid stays 0; never below -128.
REQ-030 rst_n pulsed low during CALC of neuron 1 -> all outputs 0 immediately, V[1] remains 0, first grant after release goes to lowest set req bit.
REQ-031 req[1] dropped one cycle before it would be granted while req[3] held -> gnt=1000 next, no update of neuron 1.

Source files
------------

// File: rtl/lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_scheduler
// Purpose  : Four-neuron leaky-integrate-and-fire update engine. Requests
//            are served round-robin, one update every three cycles
//            (IDLE -> CALC -> WB). Each update applies threshold/refractory
//            rules and a quadratic membrane term, saturated to 8 bits.
// Revision : 1.0 - initial release
// ============================================================================
module lif_scheduler #(
  parameter logic signed [7:0] THRESH  = 8'sd50,
  parameter logic signed [7:0] RESET_V = -8'sd20,
  parameter int unsigned       REFRAC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] i_syn,
  output logic [3:0]  gnt,
  output logic        spike_valid,
  output logic [1:0]  spike_id,
  output logic [7:0]  v_mem,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Per-neuron state
  logic signed [7:0] r_v   [4];
  logic        [1:0] r_ref [4];
  logic        [1:0] r_ptr;

  // Transaction latched at grant time
  logic        [1:0] r_idx;
  logic signed [7:0] r_isyn;

  // Result computed in CALC, committed in WB
  logic signed [7:0] r_next;
  logic        [1:0] r_ref_next;

  // Output registers
  logic              r_spike_valid;
  logic        [1:0] r_spike_id;
  logic signed [7:0] r_v_mem;

  // Arbiter results
  logic        [3:0] w_gnt;
  logic        [1:0] w_gnt_idx;
  logic              w_gnt_any;

  // Datapath
  logic signed [7:0]  w_v_cur;
  logic        [1:0]  w_ref_cur;
  logic signed [15:0] w_v16;
  logic signed [15:0] w_i16;
  logic signed [15:0] w_vs;
  logic signed [15:0] w_sum;
  logic signed [7:0]  w_sat;
  logic signed [7:0]  w_next;
  logic        [1:0]  w_ref_next;
  logic               w_fire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and round-robin arbitration (grants only in IDLE)
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 4'b0000;
    w_gnt_idx   = r_ptr;
    w_gnt_any   = 1'b0;
    case (r_state)
      S_IDLE: begin
        for (int off = 0; off < 4; off++) begin
          logic [1:0] cand;
          cand = r_ptr + 2'(off);
          if (!w_gnt_any && req[cand]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = cand;
          end
        end
        if (w_gnt_any) begin
          w_gnt[w_gnt_idx] = 1'b1;
          w_state_nxt      = S_CALC;
        end
      end
      S_CALC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Neuron update rule: fire, hold while refractory, else integrate
  always_comb begin
    w_v_cur    = r_v[r_idx];
    w_ref_cur  = r_ref[r_idx];
    w_v16      = {{8{w_v_cur[7]}}, w_v_cur};
    w_i16      = {{8{r_isyn[7]}}, r_isyn};
    w_vs       = w_v16 >>> 3;
    w_sum      = w_v16 + (w_i16 >>> 2) + (w_vs * w_vs);
    if (w_sum > 16'sd127) begin
      w_sat = 8'sd127;
    end else if (w_sum < -16'sd128) begin
      w_sat = -8'sd128;
    end else begin
      w_sat = w_sum[7:0];
    end
    w_fire     = 1'b0;
    w_next     = w_sat;
    w_ref_next = w_ref_cur;
    if (w_v_cur >= THRESH) begin
      w_fire     = 1'b1;
      w_next     = RESET_V;
      w_ref_next = 2'(REFRAC);
    end else if (w_ref_cur != 2'd0) begin
      w_next     = w_v_cur;
      w_ref_next = w_ref_cur - 2'd1;
    end
  end

  // Latch on grant, compute in CALC, commit neuron state in WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_v[k]   <= '0;
        r_ref[k] <= '0;
      end
      r_ptr         <= '0;
      r_idx         <= '0;
      r_isyn        <= '0;
      r_next        <= '0;
      r_ref_next    <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_v_mem       <= '0;
    end else begin
      r_spike_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_idx  <= w_gnt_idx;
            r_isyn <= i_syn[8*w_gnt_idx +: 8];
          end
        end
        S_CALC: begin
          r_next        <= w_next;
          r_ref_next    <= w_ref_next;
          r_v_mem       <= w_next;
          r_spike_id    <= r_idx;
          r_spike_valid <= w_fire;
        end
        S_WB: begin
          r_v[r_idx]   <= r_next;
          r_ref[r_idx] <= r_ref_next;
          r_ptr        <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Grant is combinational from IDLE; masked so reset forces it low at once
  assign gnt         = w_gnt & {4{rst_n}};
  assign spike_valid = r_spike_valid;
  assign spike_id    = r_spike_id;
  assign v_mem       = r_v_mem;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_scheduler
// Purpose  : Directed self-checking bench for lif_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] i_syn;
  logic [3:0]  gnt;
  logic        spike_valid;
  logic [1:0]  spike_id;
  logic [7:0]  v_mem;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  lif_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .i_syn       (i_syn),
    .gnt         (gnt),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .v_mem       (v_mem),
    .busy        (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant, sampled on the falling edge
  task automatic wait_gnt(output logic [3:0] g, output int n);
    g = 4'b0000;
    n = 0;
    while (g == 4'b0000 && n < 12) begin
      @(negedge clk);
      n++;
      if (gnt != 4'b0000) g = gnt;
    end
    if (g == 4'b0000) begin
      checks++;
      failures++;
      $error("FAIL gnt_timeout observed=0 expected=nonzero");
    end
  endtask

  // One full update: expect the given grant, then WB results two cycles later
  task automatic upd(input string tag, input logic [3:0] eg, input logic [7:0] ev,
                     input logic es, input logic [1:0] eid);
    logic [3:0] g;
    int         n;
    wait_gnt(g, n);
    chk({tag, "_gnt"}, {4'b0, g}, {4'b0, eg});
    @(negedge clk);
    chk({tag, "_busy"}, {7'b0, busy}, 8'd1);
    @(negedge clk);
    chk({tag, "_vmem"}, v_mem, ev);
    chk({tag, "_spk"}, {7'b0, spike_valid}, {7'b0, es});
    chk({tag, "_id"}, {6'b0, spike_id}, {6'b0, eid});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    int         n;

    rst_n = 1'b0;
    req   = 4'b0000;
    i_syn = 32'h0;
    #2;
    chk("rst_gnt",  {4'b0, gnt}, 8'd0);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_spk",  {7'b0, spike_valid}, 8'd0);
    chk("rst_vmem", v_mem, 8'd0);
    chk("rst_id",   {6'b0, spike_id}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Neuron 0, I=40: integrate to threshold, fire, refractory, resume
    @(posedge clk); #1;
    i_syn = 32'h0000_0028;
    req   = 4'b0001;
    upd("n0_u1", 4'b0001, 8'd10,  1'b0, 2'd0);
    upd("n0_u2", 4'b0001, 8'd21,  1'b0, 2'd0);
    upd("n0_u3", 4'b0001, 8'd35,  1'b0, 2'd0);
    upd("n0_u4", 4'b0001, 8'd61,  1'b0, 2'd0);
    upd("n0_u5", 4'b0001, 8'hEC,  1'b1, 2'd0);
    upd("n0_r1", 4'b0001, 8'hEC,  1'b0, 2'd0);
    upd("n0_r2", 4'b0001, 8'hEC,  1'b0, 2'd0);
    upd("n0_u8", 4'b0001, 8'hFF,  1'b0, 2'd0);
    do_reset();

    // All four requesting: round-robin order, grants 3 cycles apart
    req   = 4'b1111;
    i_syn = 32'h2828_2828;
    wait_gnt(g, n);
    chk("rr_g0", {4'b0, g}, 8'b0001);
    wait_gnt(g, n);
    chk("rr_g1", {4'b0, g}, 8'b0010);
    chk("rr_gap1", 8'(n), 8'd3);
    wait_gnt(g, n);
    chk("rr_g2", {4'b0, g}, 8'b0100);
    chk("rr_gap2", 8'(n), 8'd3);
    wait_gnt(g, n);
    chk("rr_g3", {4'b0, g}, 8'b1000);
    chk("rr_gap3", 8'(n), 8'd3);
    wait_gnt(g, n);
    chk("rr_g4", {4'b0, g}, 8'b0001);
    chk("rr_gap4", 8'(n), 8'd3);
    do_reset();

    // Neuron 2, I=-128: strongly negative input, no firing, no wrap
    i_syn = 32'h0080_0000;
    req   = 4'b0100;
    upd("n2_u1", 4'b0100, 8'hE0, 1'b0, 2'd2);
    upd("n2_u2", 4'b0100, 8'hD0, 1'b0, 2'd2);
    upd("n2_u3", 4'b0100, 8'hD4, 1'b0, 2'd2);
    upd("n2_u4", 4'b0100, 8'hD8, 1'b0, 2'd2);
    do_reset();

    // Reset in the middle of neuron 1's CALC aborts it
    i_syn = 32'h2828_2828;
    req   = 4'b0100;
    upd("pre_n2", 4'b0100, 8'd10, 1'b0, 2'd2);
    @(posedge clk); #1;
    req = 4'b0010;
    wait_gnt(g, n);
    chk("ab_gnt", {4'b0, g}, 8'b0010);
    @(posedge clk); #1;
    chk("ab_busy_pre", {7'b0, busy}, 8'd1);
    rst_n = 1'b0;
    req   = 4'b1010;
    #1;
    chk("ab_gnt0",  {4'b0, gnt}, 8'd0);
    chk("ab_busy0", {7'b0, busy}, 8'd0);
    chk("ab_spk0",  {7'b0, spike_valid}, 8'd0);
    chk("ab_vmem0", v_mem, 8'd0);
    chk("ab_id0",   {6'b0, spike_id}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    upd("ab_n1", 4'b0010, 8'd10, 1'b0, 2'd1);
    do_reset();

    // Request dropped before its grant is discarded
    i_syn = 32'h2828_2828;
    req   = 4'b0001;
    wait_gnt(g, n);
    chk("dr_g0", {4'b0, g}, 8'b0001);
    @(posedge clk); #1;
    req = 4'b1010;
    @(posedge clk); #1;
    req = 4'b1000;
    upd("dr_n3", 4'b1000, 8'd10, 1'b0, 2'd3);
    @(posedge clk); #1;
    req = 4'b0010;
    upd("dr_n1", 4'b0010, 8'd10, 1'b0, 2'd1);
    req = 4'b0000;

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
